// File: rtl/uart_tx_arbiter_if.sv
// Byte-source / transmitter bundle for uart_tx_arbiter.
// The slave modport is the arbiter's view; master is the surrounding logic's view.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 2
);
  logic [N_REQ-1:0]   req_valid_i;
  logic [8*N_REQ-1:0] req_data_i;
  logic [N_REQ-1:0]   req_ready_o;
  logic [7:0]         tx_data_o;
  logic               tx_start_o;
  logic               tx_busy_i;
  logic [N_REQ-1:0]   grant_o;
  logic               busy_o;
  logic               timeout_o;
  logic [15:0]        frames_o;

  modport slave (
    input  req_valid_i, req_data_i, tx_busy_i,
    output req_ready_o, tx_data_o, tx_start_o, grant_o, busy_o, timeout_o, frames_o
  );

  modport master (
    output req_valid_i, req_data_i, tx_busy_i,
    input  req_ready_o, tx_data_o, tx_start_o, grant_o, busy_o, timeout_o, frames_o
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte sources,
// one byte per frame, with busy-rise timeout and an enforced inter-frame gap.
module uart_tx_arbiter #(
  parameter int N_REQ        = 2,
  parameter int BUSY_TIMEOUT = 16,
  parameter int GAP_CYCLES   = 0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  uart_tx_arbiter_if.slave   bus
);

  localparam int PW      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CMAX    = (BUSY_TIMEOUT > GAP_CYCLES) ? BUSY_TIMEOUT : GAP_CYCLES;
  localparam int CW      = $clog2(CMAX + 1);
  localparam int GAP_LEN = (GAP_CYCLES > 0) ? GAP_CYCLES : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ACCEPT, S_START, S_WAIT_BUSY, S_WAIT_DONE, S_GAP
  } state_t;

  state_t           r_state, w_state_next;
  logic [PW-1:0]    r_ptr, w_ptr_next;
  logic [PW-1:0]    r_gidx, w_gidx_next;
  logic [N_REQ-1:0] r_grant, w_grant_next;
  logic [7:0]       r_data, w_data_next;
  logic [CW-1:0]    r_cnt, w_cnt_next;
  logic [15:0]      r_frames, w_frames_next;

  logic [N_REQ-1:0] w_ready;
  logic             w_start;
  logic             w_timeout;
  logic             w_pick_found;
  logic [PW-1:0]    w_pick_idx;
  logic [7:0]       w_req_byte [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_byte
      assign w_req_byte[gi] = bus.req_data_i[8*gi +: 8];
    end
  endgenerate

  // Search starts just after the last served requester, so it ranks lowest.
  always_comb begin
    logic [PW-1:0] idx;
    idx          = '0;
    w_pick_found = 1'b0;
    w_pick_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = PW'((int'(r_ptr) + k) % N_REQ);
      if (!w_pick_found && bus.req_valid_i[idx]) begin
        w_pick_found = 1'b1;
        w_pick_idx   = idx;
      end
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_ptr_next    = r_ptr;
    w_gidx_next   = r_gidx;
    w_grant_next  = r_grant;
    w_data_next   = r_data;
    w_cnt_next    = r_cnt;
    w_frames_next = r_frames;
    w_ready       = '0;
    w_start       = 1'b0;
    w_timeout     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_pick_found) begin
          w_gidx_next  = w_pick_idx;
          w_grant_next = {{(N_REQ-1){1'b0}}, 1'b1} << w_pick_idx;
          w_state_next = S_ACCEPT;
        end
      end
      S_ACCEPT: begin
        w_ready = r_grant;
        if (bus.req_valid_i[r_gidx]) begin
          w_data_next  = w_req_byte[r_gidx];
          w_ptr_next   = r_gidx;
          w_state_next = S_START;
        end else begin
          w_grant_next = '0;
          w_state_next = S_IDLE;
        end
      end
      S_START: begin
        w_start      = 1'b1;
        w_cnt_next   = '0;
        w_state_next = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (bus.tx_busy_i) begin
          w_state_next = S_WAIT_DONE;
        end else if (r_cnt == CW'(BUSY_TIMEOUT - 1)) begin
          w_timeout    = 1'b1;
          w_grant_next = '0;
          w_cnt_next   = '0;
          w_state_next = S_GAP;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!bus.tx_busy_i) begin
          w_frames_next = r_frames + 16'd1;
          w_grant_next  = '0;
          w_cnt_next    = '0;
          w_state_next  = S_GAP;
        end
      end
      S_GAP: begin
        if (r_cnt == CW'(GAP_LEN - 1)) begin
          w_state_next = S_IDLE;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: begin
        w_grant_next = '0;
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state  <= S_IDLE;
      r_ptr    <= PW'(N_REQ - 1);
      r_gidx   <= '0;
      r_grant  <= '0;
      r_data   <= '0;
      r_cnt    <= '0;
      r_frames <= '0;
    end else begin
      r_state  <= w_state_next;
      r_ptr    <= w_ptr_next;
      r_gidx   <= w_gidx_next;
      r_grant  <= w_grant_next;
      r_data   <= w_data_next;
      r_cnt    <= w_cnt_next;
      r_frames <= w_frames_next;
    end
  end

  assign bus.req_ready_o = w_ready;
  assign bus.tx_start_o  = w_start;
  assign bus.timeout_o   = w_timeout;
  assign bus.tx_data_o   = r_data;
  assign bus.grant_o     = r_grant;
  assign bus.frames_o    = r_frames;
  assign bus.busy_o      = (r_state != S_IDLE);

endmodule
